// File: rtl/riscv_user_io.sv
// rtl/riscv_user_io.sv - multi-channel memory-mapped user I/O peripheral
// Per-channel synchronised, debounced inputs with sticky change flags, plus CPU output registers.
module riscv_user_io #(
  parameter int DATA_W   = 16,
  parameter int IN_W     = 6,
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = 4,
  parameter int DEBOUNCE = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        bus_addr,
  input  logic                     bus_wr_en,
  input  logic                     bus_rd_en,
  input  logic [DATA_W-1:0]        bus_wdata,
  output logic [DATA_W-1:0]        bus_rdata,
  output logic                     bus_ready,
  input  logic [NUM_CH*IN_W-1:0]   user_in,
  output logic [NUM_CH*DATA_W-1:0] user_read,
  output logic                     irq
);

  localparam int CNT_W = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);

  logic [IN_W-1:0]   sync1_q [NUM_CH];
  logic [IN_W-1:0]   sync2_q [NUM_CH];
  logic [IN_W-1:0]   filt_q  [NUM_CH];
  logic [IN_W-1:0]   filt_d  [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d   [NUM_CH];
  logic [DATA_W-1:0] out_q   [NUM_CH];
  logic [DATA_W-1:0] out_d   [NUM_CH];
  logic [NUM_CH-1:0] status_q, status_d, irq_en_q, irq_en_d, hw_set, w1c_mask;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q;

  // Counter compares against DEBOUNCE, so DEBOUNCE=0 loads on the first differing cycle.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      filt_d[c] = filt_q[c];
      cnt_d[c]  = '0;
      hw_set[c] = 1'b0;
      if (sync2_q[c] != filt_q[c]) begin
        if (cnt_q[c] == CNT_W'(DEBOUNCE)) begin
          filt_d[c] = sync2_q[c];
          hw_set[c] = 1'b1;
        end else begin
          cnt_d[c] = cnt_q[c] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    irq_en_d = irq_en_q;
    w1c_mask = '0;
    for (int c = 0; c < NUM_CH; c++) out_d[c] = out_q[c];
    if (bus_wr_en) begin
      if (bus_addr == ADDR_W'(0)) w1c_mask = bus_wdata[NUM_CH-1:0];
      if (bus_addr == ADDR_W'(1)) irq_en_d = bus_wdata[NUM_CH-1:0];
      for (int c = 0; c < NUM_CH; c++)
        if (bus_addr == ADDR_W'(2 + NUM_CH + c)) out_d[c] = bus_wdata;
    end
    // Hardware set wins over a simultaneous clear.
    status_d = (status_q & ~w1c_mask) | hw_set;
  end

  always_comb begin
    rdata_d = '0;
    if (bus_addr == ADDR_W'(0)) rdata_d[NUM_CH-1:0] = status_q;
    if (bus_addr == ADDR_W'(1)) rdata_d[NUM_CH-1:0] = irq_en_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus_addr == ADDR_W'(2 + c))          rdata_d[IN_W-1:0] = filt_q[c];
      if (bus_addr == ADDR_W'(2 + NUM_CH + c)) rdata_d = out_q[c];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        sync1_q[c] <= '0;
        sync2_q[c] <= '0;
        filt_q[c]  <= '0;
        cnt_q[c]   <= '0;
        out_q[c]   <= '0;
      end
      status_q <= '0;
      irq_en_q <= '0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        sync1_q[c] <= user_in[c*IN_W +: IN_W];
        sync2_q[c] <= sync1_q[c];
        filt_q[c]  <= filt_d[c];
        cnt_q[c]   <= cnt_d[c];
        out_q[c]   <= out_d[c];
      end
      status_q <= status_d;
      irq_en_q <= irq_en_d;
      ready_q  <= bus_rd_en;
      if (bus_rd_en) rdata_q <= rdata_d;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_out
    assign user_read[c*DATA_W +: DATA_W] = out_q[c];
  end

  assign bus_rdata = rdata_q;
  assign bus_ready = ready_q;
  assign irq       = |(status_q & irq_en_q);

endmodule

// File: tb/tb_riscv_user_io.sv
// tb/tb_riscv_user_io.sv - scoreboard testbench for riscv_user_io
// Reads push expected data on issue; a negedge monitor pops and compares on bus_ready.
module tb_riscv_user_io;

  logic        clk, rst;
  logic [3:0]  bus_addr;
  logic        bus_wr_en, bus_rd_en;
  logic [15:0] bus_wdata, bus_rdata;
  logic        bus_ready;
  logic [11:0] user_in;
  logic [31:0] user_read;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [19:0] exp_q[$];
  logic [19:0] ent;

  riscv_user_io dut (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_wr_en(bus_wr_en),
    .bus_rd_en(bus_rd_en), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ready(bus_ready), .user_in(user_in), .user_read(user_read), .irq(irq)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (bus_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready: rdata=%h, required no ready", bus_rdata);
      end else begin
        ent = exp_q.pop_front();
        if (bus_rdata !== ent[15:0]) begin
          errors++;
          $display("FAIL read_addr%0d: got %h, required %h", ent[19:16], bus_rdata, ent[15:0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, ex);
    end
  endtask

  task automatic cyc(input logic rd, input logic wr, input logic [3:0] a,
                     input logic [15:0] wd, input logic [15:0] ex);
    @(posedge clk); #1;
    bus_rd_en = rd;
    bus_wr_en = wr;
    bus_addr  = a;
    bus_wdata = wd;
    if (rd) exp_q.push_back({a, ex});
  endtask

  task automatic rd(input logic [3:0] a, input logic [15:0] ex);
    cyc(1'b1, 1'b0, a, 16'h0, ex);
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    cyc(1'b0, 1'b1, a, d, 16'h0);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
  endtask

  initial begin
    rst = 1; bus_addr = 0; bus_wr_en = 0; bus_rd_en = 0; bus_wdata = 0; user_in = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("reset_ready", {31'h0, bus_ready}, 32'h0);
    chk("reset_rdata", {16'h0, bus_rdata}, 32'h0);
    chk("reset_user_read", user_read, 32'h0);
    chk("reset_irq", {31'h0, irq}, 32'h0);

    // ch0=28 appears in IN_0 at edge N+6; a read sampled at N+6 still sees 0.
    idle();
    user_in = {6'd0, 6'd28};
    repeat (5) idle();
    rd(4'd2, 16'd0);
    rd(4'd2, 16'd28);
    rd(4'd0, 16'h0001);
    idle();
    chk("irq_masked", {31'h0, irq}, 32'h0);

    wr(4'd1, 16'h0003);
    idle();
    chk("irq_enabled", {31'h0, irq}, 32'h1);
    wr(4'd0, 16'h0001);
    idle();
    chk("irq_cleared", {31'h0, irq}, 32'h0);
    rd(4'd0, 16'h0000);
    rd(4'd1, 16'h0003);
    idle();

    // Three-cycle glitch on ch1 must be filtered out.
    idle();
    user_in = {6'd5, 6'd28};
    repeat (3) idle();
    user_in = {6'd0, 6'd28};
    repeat (10) idle();
    rd(4'd3, 16'd0);
    rd(4'd0, 16'h0000);
    idle();
    user_in = {6'd5, 6'd28};
    repeat (8) idle();
    rd(4'd3, 16'd5);
    rd(4'd0, 16'h0002);
    idle();
    chk("irq_ch1", {31'h0, irq}, 32'h1);

    wr(4'd5, 16'hBEEF);
    idle();
    chk("user_read_ch1", {16'h0, user_read[31:16]}, 32'h0000BEEF);
    chk("user_read_ch0", {16'h0, user_read[15:0]}, 32'h0);
    rd(4'd5, 16'hBEEF);
    rd(4'd15, 16'h0000);
    cyc(1'b1, 1'b1, 4'd4, 16'h1234, 16'h0000);
    rd(4'd4, 16'h1234);
    wr(4'd2, 16'hFFFF);
    rd(4'd2, 16'd28);
    idle();
    chk("user_read_ch0_wr", {16'h0, user_read[15:0]}, 32'h00001234);

    // ch0 change lands on the same edge as a W1C of bit 0.
    wr(4'd0, 16'h0003);
    idle();
    user_in = {6'd5, 6'd7};
    repeat (5) idle();
    wr(4'd0, 16'h0001);
    rd(4'd0, 16'h0001);
    rd(4'd2, 16'd7);
    idle();

    // Reset while a read is in flight: its ready must never appear.
    @(posedge clk); #1;
    bus_rd_en = 1; bus_addr = 4'd2;
    @(posedge clk); #1;
    rst = 1; bus_rd_en = 0;
    #1 chk("ready_dropped", {31'h0, bus_ready}, 32'h0);
    @(posedge clk); #1;
    rst = 0;
    chk("post_rst_user_read", user_read, 32'h0);
    chk("post_rst_irq", {31'h0, irq}, 32'h0);
    chk("post_rst_rdata", {16'h0, bus_rdata}, 32'h0);
    rd(4'd0, 16'h0);
    rd(4'd1, 16'h0);
    rd(4'd2, 16'h0);
    rd(4'd3, 16'h0);
    rd(4'd4, 16'h0);
    rd(4'd5, 16'h0);
    repeat (8) idle();
    rd(4'd0, 16'h0003);
    rd(4'd2, 16'd7);
    rd(4'd3, 16'd5);
    idle();
    repeat (3) idle();

    chk("scoreboard_drained", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
